packet_sorter: RTL and testbench
================================

// Module: packet_sorter
// PURPOSE
//  Streaming packet sorter. Captures one packet of up to 2**ADR_WIDTH words from a
//  sop/eop/val stream, sorts it ascending (unsigned), then replays it as one
//  contiguous sop/eop/val packet. busy_o back-pressures the upstream source.
//  It sits between a packet source (e.g. a sequence generator) and a downstream consumer.
// PARAMETERS
//  DATA_WIDTH  8  word width in bits
//  ADR_WIDTH   3  log2 of max packet length (N = 2**ADR_WIDTH words)
// PORTS
//  clk_i    in   1           single clock, all logic on rising edge
//  rst_n_i  in   1           reset, synchronous, active-low
//  sop_i    in   1           first word of input packet (qualified by val_i)
//  eop_i    in   1           last word of input packet (qualified by val_i)
//  data_i   in   DATA_WIDTH  input word
//  val_i    in   1           input word valid
//  sop_o    out  1           first word of sorted packet
//  eop_o    out  1           last word of sorted packet
//  data_o   out  DATA_WIDTH  sorted output word
//  val_o    out  1           output word valid
//  busy_o   out  1           high while sorting/replaying; input ignored when high
// BEHAVIOUR
//  - Reset (rst_n_i=0 at a clock edge): state=IDLE, len=0; all outputs 0. Reset
//    mid-packet or mid-sort discards the packet.
//  - Storage: register array mem[0..N-1]. All outputs are registered.
//  - States IDLE -> RECV -> SORT -> OUT -> IDLE.
//  - IDLE: words without sop_i are ignored. val_i&sop_i: fill mem[1..N-1] with
//    all-ones, write mem[0]=data_i, len=1. If eop_i is also high, go to SORT;
//    otherwise go to RECV.
//  - RECV: on each val_i, write mem[len]=data_i and increment len.
//    val_i&eop_i -> SORT. val_i&sop_i restarts the packet as in IDLE.
//    Overflow: words beyond N are dropped, len saturates at N, and eop_i still ends the packet.
//  - SORT: exactly N cycles of odd-even transposition sort over the whole array.
//    Cycle k compares/swaps pairs (i,i+1) with i%2==k%2, smaller value to the lower index.
//    All-ones padding sinks to the top, so mem[0..len-1] holds the sorted packet.
//  - OUT: emit mem[0..len-1] on consecutive cycles with val_o=1. sop_o=1 on the
//    first word and eop_o=1 on the last; both are 1 for len=1. Then go to IDLE.
//  - Output idle values: val_o/sop_o/eop_o=0, data_o=0.
//  - busy_o=1 in SORT and OUT, and 0 in IDLE/RECV.
//  - Timing: eop word accepted at edge T. busy_o=1 from T+1. SORT covers cycles
//    T+1..T+N. Output words appear at T+N+1..T+N+len. busy_o=0 from the cycle
//    after eop_o, when a new sop_i is accepted.
//  - Inputs presented while busy_o=1 are ignored. Equal values may appear in any order.
// TESTING
//  1. 8 words FA,AA,56,12,AD,C8,BC,05 (sop on first, eop on last) -> busy_o for 16 cycles;
//     output 05,12,56,AA,AD,BC,C8,FA with sop_o on 05 and eop_o on FA.
//  2. 1 word FF with sop_i=eop_i=1 -> single output FF with sop_o=eop_o=val_o=1,
//     8 cycles after busy_o rises.
//  3. 2 words FF,AA -> AA (sop_o), FF (eop_o). Then 4 words 5F,AA,65,11, sent once
//     busy_o falls -> 11,5F,65,AA.
//  4. 10 words 09..00 without eop until the 10th word -> len saturates at 8;
//     output 02,03,...,09 in ascending order.
//  5. Words driven while busy_o=1, and val_i without sop_i in IDLE -> ignored,
//     with no change to output.
//  6. rst_n_i=0 during SORT -> all outputs 0 on the next edge, no output packet;
//     a fresh packet then sorts correctly.

Source files
------------

// File: rtl/packet_sorter.sv
// rtl/packet_sorter.sv - capture one packet, odd-even transposition sort it, replay it ascending
module packet_sorter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADR_WIDTH  = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  sop_i,
    input  logic                  eop_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  val_i,
    output logic                  sop_o,
    output logic                  eop_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  val_o,
    output logic                  busy_o
);

    localparam int N = 2 ** ADR_WIDTH;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RECV = 2'd1;
    localparam logic [1:0] ST_SORT = 2'd2;
    localparam logic [1:0] ST_OUT  = 2'd3;

    localparam logic [ADR_WIDTH:0]   LEN_ONE   = (ADR_WIDTH + 1)'(1);
    localparam logic [ADR_WIDTH:0]   LEN_MAX   = (ADR_WIDTH + 1)'(N);
    localparam logic [ADR_WIDTH-1:0] STEP_LAST = {ADR_WIDTH{1'b1}};

    logic [1:0]            state;
    logic [DATA_WIDTH-1:0] mem [N];
    logic [DATA_WIDTH-1:0] swp [N];
    logic [ADR_WIDTH:0]    len;
    logic [ADR_WIDTH:0]    rd;
    logic [ADR_WIDTH-1:0]  step;

    // One transposition pass: pairs whose lower index parity matches the step parity
    // are ordered so the smaller value lands on the lower index. Pairs are disjoint,
    // so every pair reads the current array.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            swp[i] = mem[i];
        end
        for (int i = 0; i < N - 1; i++) begin
            if ((i % 2 == 1) == step[0]) begin
                if (mem[i] > mem[i+1]) begin
                    swp[i]   = mem[i+1];
                    swp[i+1] = mem[i];
                end
            end
        end
    end

    // Capture / sort / replay sequencer with registered outputs.
    // The final sort pass also launches the first output word, so the packet appears
    // immediately after the N sort cycles.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state  <= ST_IDLE;
            len    <= '0;
            rd     <= '0;
            step   <= '0;
            sop_o  <= 1'b0;
            eop_o  <= 1'b0;
            val_o  <= 1'b0;
            data_o <= '0;
            busy_o <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_RECV: begin
                    if (val_i && sop_i) begin
                        // Padding with all-ones lets unused slots sink past the packet.
                        for (int i = 1; i < N; i++) begin
                            mem[i] <= {DATA_WIDTH{1'b1}};
                        end
                        mem[0] <= data_i;
                        len    <= LEN_ONE;
                        if (eop_i) begin
                            state  <= ST_SORT;
                            step   <= '0;
                            busy_o <= 1'b1;
                        end else begin
                            state <= ST_RECV;
                        end
                    end else if (state == ST_RECV && val_i) begin
                        // Words past the array size are dropped; len saturates.
                        if (len < LEN_MAX) begin
                            mem[len[ADR_WIDTH-1:0]] <= data_i;
                            len                     <= len + LEN_ONE;
                        end
                        if (eop_i) begin
                            state  <= ST_SORT;
                            step   <= '0;
                            busy_o <= 1'b1;
                        end
                    end
                end

                ST_SORT: begin
                    mem  <= swp;
                    step <= step + 1'b1;
                    if (step == STEP_LAST) begin
                        data_o <= swp[0];
                        val_o  <= 1'b1;
                        sop_o  <= 1'b1;
                        eop_o  <= (len == LEN_ONE);
                        rd     <= LEN_ONE;
                        state  <= ST_OUT;
                    end
                end

                default: begin
                    if (rd == len) begin
                        val_o  <= 1'b0;
                        sop_o  <= 1'b0;
                        eop_o  <= 1'b0;
                        data_o <= '0;
                        busy_o <= 1'b0;
                        state  <= ST_IDLE;
                    end else begin
                        data_o <= mem[rd[ADR_WIDTH-1:0]];
                        val_o  <= 1'b1;
                        sop_o  <= 1'b0;
                        eop_o  <= (rd + LEN_ONE == len);
                        rd     <= rd + LEN_ONE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_packet_sorter.sv
// tb/tb_packet_sorter.sv - randomized self-checking bench for packet_sorter
module tb_packet_sorter;

    localparam int DW = 8;
    localparam int AW = 3;
    localparam int N  = 2 ** AW;

    typedef logic [DW-1:0] word_q_t[$];

    logic          clk = 1'b0;
    logic          rst_n;
    logic          sop_i, eop_i, val_i;
    logic [DW-1:0] data_i;
    logic          sop_o, eop_o, val_o, busy_o;
    logic [DW-1:0] data_o;

    int errors = 0;
    int checks = 0;

    packet_sorter #(.DATA_WIDTH(DW), .ADR_WIDTH(AW)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .sop_i   (sop_i),
        .eop_i   (eop_i),
        .data_i  (data_i),
        .val_i   (val_i),
        .sop_o   (sop_o),
        .eop_o   (eop_o),
        .data_o  (data_o),
        .val_o   (val_o),
        .busy_o  (busy_o)
    );

    always #5 clk = ~clk;

    // Reference: keep the first N words of the packet and sort them ascending.
    function automatic word_q_t ref_sort(input word_q_t pkt);
        word_q_t res;
        res = {};
        foreach (pkt[i]) begin
            if (i < N) res.push_back(pkt[i]);
        end
        res.sort();
        return res;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        val_i  = 1'b0;
        sop_i  = 1'b0;
        eop_i  = 1'b0;
        data_i = '0;
    endtask

    task automatic junk_inputs;
        val_i  = 1'b1;
        sop_i  = 1'($urandom_range(0, 1));
        eop_i  = 1'($urandom_range(0, 1));
        data_i = DW'($urandom);
    endtask

    // Send one packet, then check the full sort/replay timeline cycle by cycle.
    task automatic run_packet(input word_q_t pkt, input bit junk, input bit gaps, input string name);
        word_q_t exp;
        int      len;
        exp = ref_sort(pkt);
        len = exp.size();
        foreach (pkt[i]) begin
            if (gaps && i > 0 && $urandom_range(0, 2) == 0) begin
                idle_inputs();
                tick();
            end
            val_i  = 1'b1;
            sop_i  = (i == 0);
            eop_i  = (i == pkt.size() - 1);
            data_i = pkt[i];
            tick();
        end
        idle_inputs();
        for (int c = 1; c <= N; c++) begin
            checks++;
            if (busy_o !== 1'b1 || val_o !== 1'b0) begin
                errors++;
                $display("FAIL %s sort cycle %0d: busy=%b val=%b want busy=1 val=0", name, c, busy_o, val_o);
            end
            if (junk) junk_inputs();
            tick();
        end
        for (int j = 0; j < len; j++) begin
            checks++;
            if (val_o !== 1'b1 || data_o !== exp[j] || sop_o !== (j == 0) ||
                eop_o !== (j == len - 1) || busy_o !== 1'b1) begin
                errors++;
                $display("FAIL %s word %0d: val=%b data=%h sop=%b eop=%b busy=%b want val=1 data=%h sop=%b eop=%b busy=1",
                         name, j, val_o, data_o, sop_o, eop_o, busy_o, exp[j], j == 0, j == len - 1);
            end
            if (junk) junk_inputs();
            tick();
        end
        idle_inputs();
        checks++;
        if (busy_o !== 1'b0 || val_o !== 1'b0 || sop_o !== 1'b0 || eop_o !== 1'b0 || data_o !== '0) begin
            errors++;
            $display("FAIL %s after packet: busy=%b val=%b sop=%b eop=%b data=%h want all 0",
                     name, busy_o, val_o, sop_o, eop_o, data_o);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        idle_inputs();
        repeat (3) tick();
        checks++;
        if (val_o !== 1'b0 || sop_o !== 1'b0 || eop_o !== 1'b0 || data_o !== '0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset outputs: val=%b sop=%b eop=%b data=%h busy=%b want all 0",
                     val_o, sop_o, eop_o, data_o, busy_o);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_full_packet;
        word_q_t p;
        p = '{8'hFA, 8'hAA, 8'h56, 8'h12, 8'hAD, 8'hC8, 8'hBC, 8'h05};
        run_packet(p, 1'b0, 1'b0, "full8");
    endtask

    task automatic test_single;
        word_q_t p;
        p = '{8'hFF};
        run_packet(p, 1'b0, 1'b0, "single");
    endtask

    task automatic test_back_to_back;
        word_q_t p;
        p = '{8'hFF, 8'hAA};
        run_packet(p, 1'b0, 1'b0, "b2b_first");
        p = '{8'h5F, 8'hAA, 8'h65, 8'h11};
        run_packet(p, 1'b0, 1'b0, "b2b_second");
    endtask

    task automatic test_overflow;
        word_q_t p;
        p = {};
        for (int i = 9; i >= 0; i--) p.push_back(DW'(i));
        run_packet(p, 1'b0, 1'b0, "overflow");
    endtask

    task automatic test_ignored;
        word_q_t p;
        for (int i = 0; i < 4; i++) begin
            val_i  = 1'b1;
            sop_i  = 1'b0;
            eop_i  = (i == 3);
            data_i = DW'($urandom);
            tick();
            checks++;
            if (val_o !== 1'b0 || busy_o !== 1'b0) begin
                errors++;
                $display("FAIL idle_no_sop cycle %0d: val=%b busy=%b want 0 0", i, val_o, busy_o);
            end
        end
        idle_inputs();
        p = '{8'h33, 8'h01, 8'hFE};
        run_packet(p, 1'b1, 1'b0, "junk_while_busy");
    endtask

    task automatic test_reset_mid_sort;
        word_q_t p;
        p = '{8'h40, 8'h30, 8'h20, 8'h10, 8'h00};
        foreach (p[i]) begin
            val_i  = 1'b1;
            sop_i  = (i == 0);
            eop_i  = (i == p.size() - 1);
            data_i = p[i];
            tick();
        end
        idle_inputs();
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        checks++;
        if (val_o !== 1'b0 || sop_o !== 1'b0 || eop_o !== 1'b0 || data_o !== '0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_sort_reset: val=%b sop=%b eop=%b data=%h busy=%b want all 0",
                     val_o, sop_o, eop_o, data_o, busy_o);
        end
        rst_n = 1'b1;
        for (int c = 0; c < N + 10; c++) begin
            tick();
            checks++;
            if (val_o !== 1'b0 || busy_o !== 1'b0) begin
                errors++;
                $display("FAIL discarded_packet cycle %0d: val=%b busy=%b want 0 0", c, val_o, busy_o);
            end
        end
        p = '{8'h9C, 8'h07, 8'h9C, 8'h80};
        run_packet(p, 1'b0, 1'b0, "after_reset");
    endtask

    task automatic test_random;
        word_q_t p;
        int      n;
        for (int t = 0; t < 25; t++) begin
            n = $urandom_range(1, N + 3);
            p = {};
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) p.push_back(8'hFF);
                else p.push_back(DW'($urandom));
            end
            run_packet(p, 1'($urandom_range(0, 1)), 1'b1, $sformatf("random%0d", t));
            repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_full_packet();
        test_single();
        test_back_to_back();
        test_overflow();
        test_ignored();
        test_reset_mid_sort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
